// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: grant to rvalid takes MEM_LAT+1 cycles, one access per MEM_LAT+2.
// gnt is given only in IDLE, so requesters hold req; `define MEM_ARB_RR_EN for round-robin ties (default: LSU wins).
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [63:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [3:0]  lsu_wlen,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [63:0] lsu_rdata,
  output logic [63:0] mm_addr,
  output logic [63:0] mm_wdata,
  output logic [3:0]  mm_wlen,
  output logic        mm_wen,
  output logic        mm_ren,
  input  logic [63:0] mm_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_own_lsu;
  logic          r_wen;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [3:0]    r_wlen;
  logic          r_ifu_rvalid;
  logic          r_lsu_rvalid;
  logic [63:0]   r_ifu_rdata;
  logic [63:0]   r_lsu_rdata;

  logic          w_idle;
  logic          w_busy;
  logic          w_pick_lsu;
  logic          w_grant;

`ifdef MEM_ARB_RR_EN
  logic          r_last_lsu;
  // On a tie the port that did not win last time goes first.
  assign w_pick_lsu = lsu_req && (!ifu_req || !r_last_lsu);
`else
  assign w_pick_lsu = lsu_req;
`endif

  // Grants are held off during reset so a request is never accepted and then dropped.
  assign w_idle  = (r_state == IDLE) && !rst;
  assign w_busy  = (r_state == BUSY);
  assign lsu_gnt = w_idle && w_pick_lsu;
  assign ifu_gnt = w_idle && ifu_req && !w_pick_lsu;
  assign w_grant = lsu_gnt || ifu_gnt;

  assign mm_addr  = w_busy ? r_addr  : '0;
  assign mm_wdata = w_busy ? r_wdata : '0;
  assign mm_wlen  = w_busy ? r_wlen  : '0;
  assign mm_ren   = w_busy && !r_wen;
  // Write strobe only on the final BUSY cycle so a store lands exactly once.
  assign mm_wen   = w_busy && r_wen && (r_cnt == '0);

  assign ifu_rvalid = r_ifu_rvalid;
  assign lsu_rvalid = r_lsu_rvalid;
  assign ifu_rdata  = r_ifu_rdata;
  assign lsu_rdata  = r_lsu_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_own_lsu    <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wlen       <= '0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_ifu_rdata  <= '0;
      r_lsu_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_lsu   <= 1'b1;
`endif
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state   <= BUSY;
            r_cnt     <= CNT_INIT;
            r_own_lsu <= w_pick_lsu;
            r_addr    <= w_pick_lsu ? lsu_addr : ifu_addr;
            r_wen     <= w_pick_lsu && lsu_wen;
            r_wdata   <= w_pick_lsu ? lsu_wdata : '0;
            r_wlen    <= w_pick_lsu ? lsu_wlen : '0;
`ifdef MEM_ARB_RR_EN
            r_last_lsu <= w_pick_lsu;
`endif
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            if (r_own_lsu) begin
              r_lsu_rvalid <= 1'b1;
              r_lsu_rdata  <= r_wen ? '0 : mm_rdata;
            end else begin
              r_ifu_rvalid <= 1'b1;
              r_ifu_rdata  <= mm_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A runs MEM_LAT=1, instance B MEM_LAT=3.
// Stimulus queues expected events with their cycle; a negedge monitor pops and compares every DUT event.
module tb_mem_port_arbiter;

  localparam int K_GI = 0, K_GL = 1, K_RD = 2, K_WR = 3, K_RI = 4, K_RL = 5;

  typedef struct packed {
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        lsu_req;
    logic        lsu_wen;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [3:0]  lsu_wlen;
  } in_t;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] dat;
    logic [63:0] addr;
    logic [3:0]  len;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  ia = '0;
  in_t  ib = '0;
  int   cyc = 0;
  int   vec = 0;
  int   miss = 0;
  logic chk_zero = 1'b0;
  logic done = 1'b0;
  ev_t  qa[$];
  ev_t  qb[$];

  logic        a_ifu_gnt, a_ifu_rvalid, a_lsu_gnt, a_lsu_rvalid, a_mm_wen, a_mm_ren;
  logic [63:0] a_ifu_rdata, a_lsu_rdata, a_mm_addr, a_mm_wdata, a_mm_rdata;
  logic [3:0]  a_mm_wlen;
  logic        b_ifu_gnt, b_ifu_rvalid, b_lsu_gnt, b_lsu_rvalid, b_mm_wen, b_mm_ren;
  logic [63:0] b_ifu_rdata, b_lsu_rdata, b_mm_addr, b_mm_wdata, b_mm_rdata;
  logic [3:0]  b_mm_wlen;

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return (a == 64'h8000_0000) ? 64'h13 : (a ^ 64'h0123_4567_89AB_CDEF);
  endfunction

  assign a_mm_rdata = mem_fn(a_mm_addr);
  assign b_mm_rdata = mem_fn(b_mm_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .ifu_req(ia.ifu_req), .ifu_addr(ia.ifu_addr), .ifu_gnt(a_ifu_gnt),
    .ifu_rvalid(a_ifu_rvalid), .ifu_rdata(a_ifu_rdata),
    .lsu_req(ia.lsu_req), .lsu_wen(ia.lsu_wen), .lsu_addr(ia.lsu_addr),
    .lsu_wdata(ia.lsu_wdata), .lsu_wlen(ia.lsu_wlen), .lsu_gnt(a_lsu_gnt),
    .lsu_rvalid(a_lsu_rvalid), .lsu_rdata(a_lsu_rdata),
    .mm_addr(a_mm_addr), .mm_wdata(a_mm_wdata), .mm_wlen(a_mm_wlen),
    .mm_wen(a_mm_wen), .mm_ren(a_mm_ren), .mm_rdata(a_mm_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .ifu_req(ib.ifu_req), .ifu_addr(ib.ifu_addr), .ifu_gnt(b_ifu_gnt),
    .ifu_rvalid(b_ifu_rvalid), .ifu_rdata(b_ifu_rdata),
    .lsu_req(ib.lsu_req), .lsu_wen(ib.lsu_wen), .lsu_addr(ib.lsu_addr),
    .lsu_wdata(ib.lsu_wdata), .lsu_wlen(ib.lsu_wlen), .lsu_gnt(b_lsu_gnt),
    .lsu_rvalid(b_lsu_rvalid), .lsu_rdata(b_lsu_rdata),
    .mm_addr(b_mm_addr), .mm_wdata(b_mm_wdata), .mm_wlen(b_mm_wlen),
    .mm_wen(b_mm_wen), .mm_ren(b_mm_ren), .mm_rdata(b_mm_rdata)
  );

  function automatic string kname(input int k);
    case (k)
      K_GI:    return "ifu_gnt";
      K_GL:    return "lsu_gnt";
      K_RD:    return "mm_read";
      K_WR:    return "mm_write";
      K_RI:    return "ifu_rvalid";
      default: return "lsu_rvalid";
    endcase
  endfunction

  task automatic exp(input int inst, input int kind, input int c,
                     input logic [63:0] d, input logic [63:0] a, input logic [3:0] l);
    ev_t e;
    e.kind = kind; e.cyc = c; e.dat = d; e.addr = a; e.len = l;
    if (inst == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic chk(input int inst, input int kind,
                     input logic [63:0] d, input logic [63:0] a, input logic [3:0] l);
    ev_t e;
    vec++;
    if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
      miss++;
      $display("FAIL unexpected_%s inst%0d cyc %0d: got dat %h addr %h len %h, expected no event",
               kname(kind), inst, cyc, d, a, l);
      return;
    end
    e = (inst == 0) ? qa.pop_front() : qb.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.dat !== d || e.addr !== a || e.len !== l) begin
      miss++;
      $display("FAIL %s inst%0d: got %s cyc %0d dat %h addr %h len %h, expected %s cyc %0d dat %h addr %h len %h",
               kname(e.kind), inst, kname(kind), cyc, d, a, l,
               kname(e.kind), e.cyc, e.dat, e.addr, e.len);
    end
  endtask

  always @(negedge clk) begin
    if (a_ifu_gnt)    chk(0, K_GI, '0, '0, '0);
    if (a_lsu_gnt)    chk(0, K_GL, '0, '0, '0);
    if (a_mm_ren)     chk(0, K_RD, '0, a_mm_addr, '0);
    if (a_mm_wen)     chk(0, K_WR, a_mm_wdata, a_mm_addr, a_mm_wlen);
    if (a_ifu_rvalid) chk(0, K_RI, a_ifu_rdata, '0, '0);
    if (a_lsu_rvalid) chk(0, K_RL, a_lsu_rdata, '0, '0);
    if (b_ifu_gnt)    chk(1, K_GI, '0, '0, '0);
    if (b_lsu_gnt)    chk(1, K_GL, '0, '0, '0);
    if (b_mm_ren)     chk(1, K_RD, '0, b_mm_addr, '0);
    if (b_mm_wen)     chk(1, K_WR, b_mm_wdata, b_mm_addr, b_mm_wlen);
    if (b_ifu_rvalid) chk(1, K_RI, b_ifu_rdata, '0, '0);
    if (b_lsu_rvalid) chk(1, K_RL, b_lsu_rdata, '0, '0);
    if (chk_zero) begin
      vec += 2;
      if ({a_ifu_gnt, a_lsu_gnt, a_ifu_rvalid, a_lsu_rvalid, a_mm_wen, a_mm_ren} != 6'b0 ||
          a_ifu_rdata != 0 || a_lsu_rdata != 0 || a_mm_addr != 0 || a_mm_wdata != 0 || a_mm_wlen != 0) begin
        miss++;
        $display("FAIL reset_outputs inst0 cyc %0d: got ctl %b irdata %h lrdata %h addr %h wdata %h wlen %h, expected all 0",
                 cyc, {a_ifu_gnt, a_lsu_gnt, a_ifu_rvalid, a_lsu_rvalid, a_mm_wen, a_mm_ren},
                 a_ifu_rdata, a_lsu_rdata, a_mm_addr, a_mm_wdata, a_mm_wlen);
      end
      if ({b_ifu_gnt, b_lsu_gnt, b_ifu_rvalid, b_lsu_rvalid, b_mm_wen, b_mm_ren} != 6'b0 ||
          b_ifu_rdata != 0 || b_lsu_rdata != 0 || b_mm_addr != 0 || b_mm_wdata != 0 || b_mm_wlen != 0) begin
        miss++;
        $display("FAIL reset_outputs inst1 cyc %0d: got ctl %b irdata %h lrdata %h addr %h wdata %h wlen %h, expected all 0",
                 cyc, {b_ifu_gnt, b_lsu_gnt, b_ifu_rvalid, b_lsu_rvalid, b_mm_wen, b_mm_ren},
                 b_ifu_rdata, b_lsu_rdata, b_mm_addr, b_mm_wdata, b_mm_wlen);
      end
    end
    if (done) begin
      vec += 2;
      if (qa.size() != 0) begin
        miss++;
        $display("FAIL missing_events inst0: got %0d outstanding, expected 0 (next %s cyc %0d)",
                 qa.size(), kname(qa[0].kind), qa[0].cyc);
      end
      if (qb.size() != 0) begin
        miss++;
        $display("FAIL missing_events inst1: got %0d outstanding, expected 0 (next %s cyc %0d)",
                 qb.size(), kname(qb[0].kind), qb[0].cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int t, s, u, v;
    repeat (3) step();
    rst = 1'b0;
    chk_zero = 1'b1;
    step();
    chk_zero = 1'b0;

    // A: single fetch at MEM_LAT=1, then a load queued right behind it.
    t = cyc;
    ia.ifu_req = 1'b1; ia.ifu_addr = 64'h8000_0000;
    exp(0, K_GI, t, '0, '0, '0);
    exp(0, K_RD, t + 1, '0, 64'h8000_0000, '0);
    exp(0, K_RI, t + 2, 64'h13, '0, '0);
    to_cyc(t + 1);
    ia.ifu_req = 1'b0;
    ia.lsu_req = 1'b1; ia.lsu_wen = 1'b0; ia.lsu_addr = 64'h1000;
    exp(0, K_GL, t + 3, '0, '0, '0);
    exp(0, K_RD, t + 4, '0, 64'h1000, '0);
    exp(0, K_RL, t + 5, mem_fn(64'h1000), '0, '0);
    to_cyc(t + 4);
    ia.lsu_req = 1'b0;

    // A: held ties; last grant was the LSU load.
    s = t + 6;
    to_cyc(s);
    ia.ifu_req = 1'b1; ia.ifu_addr = 64'h8000_0040;
    ia.lsu_req = 1'b1; ia.lsu_addr = 64'h2000;
`ifdef MEM_ARB_RR_EN
    exp(0, K_GI, s, '0, '0, '0);
    exp(0, K_RD, s + 1, '0, 64'h8000_0040, '0);
    exp(0, K_RI, s + 2, mem_fn(64'h8000_0040), '0, '0);
    exp(0, K_GL, s + 3, '0, '0, '0);
    exp(0, K_RD, s + 4, '0, 64'h2000, '0);
    exp(0, K_RL, s + 5, mem_fn(64'h2000), '0, '0);
    exp(0, K_GI, s + 6, '0, '0, '0);
    exp(0, K_RD, s + 7, '0, 64'h8000_0080, '0);
    exp(0, K_RI, s + 8, mem_fn(64'h8000_0080), '0, '0);
    to_cyc(s + 1);
    ia.ifu_req = 1'b0;
    to_cyc(s + 4);
    ia.lsu_req = 1'b0;
`else
    exp(0, K_GL, s, '0, '0, '0);
    exp(0, K_RD, s + 1, '0, 64'h2000, '0);
    exp(0, K_RL, s + 2, mem_fn(64'h2000), '0, '0);
    exp(0, K_GI, s + 3, '0, '0, '0);
    exp(0, K_RD, s + 4, '0, 64'h8000_0040, '0);
    exp(0, K_RI, s + 5, mem_fn(64'h8000_0040), '0, '0);
    exp(0, K_GL, s + 6, '0, '0, '0);
    exp(0, K_RD, s + 7, '0, 64'h3000, '0);
    exp(0, K_RL, s + 8, mem_fn(64'h3000), '0, '0);
    to_cyc(s + 1);
    ia.lsu_req = 1'b0;
    to_cyc(s + 4);
    ia.ifu_req = 1'b0;
`endif
    to_cyc(s + 6);
    ia.ifu_req = 1'b1; ia.ifu_addr = 64'h8000_0080;
    ia.lsu_req = 1'b1; ia.lsu_addr = 64'h3000;
    to_cyc(s + 7);
    ia.ifu_req = 1'b0; ia.lsu_req = 1'b0;

    // B: store at MEM_LAT=3, written once on the last BUSY cycle.
    t = s + 10;
    to_cyc(t);
    ib.lsu_req = 1'b1; ib.lsu_wen = 1'b1; ib.lsu_addr = 64'h8000_0100;
    ib.lsu_wdata = 64'hDEAD_BEEF; ib.lsu_wlen = 4'b1111;
    exp(1, K_GL, t, '0, '0, '0);
    exp(1, K_WR, t + 3, 64'hDEAD_BEEF, 64'h8000_0100, 4'b1111);
    exp(1, K_RL, t + 4, '0, '0, '0);
    to_cyc(t + 1);
    ib.lsu_req = 1'b0;

    // B: one-cycle IFU request while the LSU load owns the port is ignored.
    u = t + 5;
    to_cyc(u);
    ib.lsu_req = 1'b1; ib.lsu_wen = 1'b0; ib.lsu_addr = 64'h4000;
    exp(1, K_GL, u, '0, '0, '0);
    exp(1, K_RD, u + 1, '0, 64'h4000, '0);
    exp(1, K_RD, u + 2, '0, 64'h4000, '0);
    exp(1, K_RD, u + 3, '0, 64'h4000, '0);
    exp(1, K_RL, u + 4, mem_fn(64'h4000), '0, '0);
    to_cyc(u + 1);
    ib.lsu_req = 1'b0;
    ib.ifu_req = 1'b1; ib.ifu_addr = 64'h9000;
    to_cyc(u + 2);
    ib.ifu_req = 1'b0;

    // B: reset in the middle BUSY cycle of a store; nothing written, rdata cleared.
    v = u + 5;
    to_cyc(v);
    ib.lsu_req = 1'b1; ib.lsu_wen = 1'b1; ib.lsu_addr = 64'h8000_0200;
    ib.lsu_wdata = 64'h1234; ib.lsu_wlen = 4'b0011;
    exp(1, K_GL, v, '0, '0, '0);
    to_cyc(v + 1);
    ib.lsu_req = 1'b0;
    to_cyc(v + 2);
    rst = 1'b1;
    to_cyc(v + 3);
    rst = 1'b0;
    chk_zero = 1'b1;
    to_cyc(v + 4);
    chk_zero = 1'b0;
    to_cyc(v + 8);
    done = 1'b1;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single pipeline memory port (`mm_addr`/`mm_wdata`/`mm_wlen`/`mm_wen`/`mm_ren`/`mm_rdata`) between the instruction-fetch unit (IFU, read-only) and the load/store stage (LSU, read or write). Each requester issues one request at a time with a req/gnt handshake. The block latches the winning request, holds it on the memory port for `MEM_LAT` cycles, and returns a one-cycle response pulse to the owner. It sits between the IFU/memory-stage logic and the memory model.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles the memory port is held per access; legal range ≥1.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ifu_req` in 1: fetch request; held with `ifu_addr` stable until `ifu_gnt`.
- `ifu_addr` in 64: fetch address.
- `ifu_gnt` out 1: request accepted this cycle (combinational).
- `ifu_rvalid` out 1: one-cycle response pulse.
- `ifu_rdata` out 64: fetched data; valid while `ifu_rvalid`, held until the next IFU response.
- `lsu_req` in 1: load/store request; held with its fields until `lsu_gnt`.
- `lsu_wen` in 1: 1 = store, 0 = load.
- `lsu_addr` in 64: access address.
- `lsu_wdata` in 64: store data.
- `lsu_wlen` in 4: store length code, passed unchanged to `mm_wlen`.
- `lsu_gnt` out 1: request accepted this cycle (combinational).
- `lsu_rvalid` out 1: one-cycle completion pulse, for loads and stores.
- `lsu_rdata` out 64: load data; 0 after a store; held until the next LSU response.
- `mm_addr` out 64, `mm_wdata` out 64, `mm_wlen` out 4, `mm_wen` out 1, `mm_ren` out 1: memory request.
- `mm_rdata` in 64: memory read data, combinational from `mm_addr`.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset value: IDLE.
- IDLE:
  - If any request is present, select a winner and assert that port's `gnt` in the same cycle.
  - On the edge, latch owner, addr, wen, wdata and wlen; load the counter with `MEM_LAT-1`; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - `mm_addr`/`mm_wdata`/`mm_wlen` are driven from the latched registers.
  - `mm_ren` = !wen for every BUSY cycle.
  - `mm_wen` = wen only in the BUSY cycle where counter==0, so each store is written exactly once.
  - Counter decrements each cycle.
  - At counter==0: capture the owner's rdata (`mm_rdata` for a load, 0 for a store) and go to RESP.
- RESP:
  - Assert the owner's `rvalid` for this cycle only.
  - All `mm_*` outputs are 0.
  - Go to IDLE unconditionally; no grant is issued in RESP.
- Outside BUSY, `mm_addr`, `mm_wdata`, `mm_wlen`, `mm_wen` and `mm_ren` are all 0.
- Arbitration (default, fixed priority): LSU beats IFU when both request in the same IDLE cycle.
- A requester may drop `req` before `gnt` without effect. Request fields are sampled only in the grant cycle.
- `gnt` is never asserted outside IDLE, and never to both ports in the same cycle.
- Reset while in BUSY or RESP:
  - Next state is IDLE; the in-flight access is abandoned with no `rvalid`.
  - A store whose counter had not reached 0 is not written.
  - `ifu_rdata` and `lsu_rdata` are cleared to 0.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; last-owner register = LSU.
- Grant to `rvalid` latency: MEM_LAT+1 cycles. Grant in cycle T, BUSY in T+1..T+MEM_LAT, `rvalid` in T+MEM_LAT+1.
- Earliest next grant is cycle T+MEM_LAT+2, so throughput is one access per MEM_LAT+2 cycles.
- `rdata` is registered: `mm_rdata` is sampled on the final BUSY edge and does not need to be stable in RESP.
- `gnt` depends combinationally on `req` and state only, never on the address or data fields.

## Configuration
- `MEM_ARB_RR_EN`, defined: round-robin arbitration.
  - On a tie, the port that was not the most recent grantee wins.
  - The last-owner register updates on every grant and resets to LSU, so the first tie after reset goes to IFU.
  - A lone requester is always granted.
- Undefined: fixed LSU-over-IFU priority; the last-owner register is absent.

## Test plan
- Single fetch, MEM_LAT=1, `ifu_addr`=0x8000_0000, memory returns 0x0000_0013:
  - `ifu_gnt` in cycle 0.
  - `mm_ren`=1 and `mm_addr`=0x8000_0000 in cycle 1 only.
  - `ifu_rvalid`=1 with `ifu_rdata`=0x13 in cycle 2.
  - Next grant no earlier than cycle 3.
- Store, MEM_LAT=3, `lsu_wen`=1, addr 0x8000_0100, wdata 0xDEAD_BEEF, wlen 4'b1111:
  - `mm_wen` high only in cycle 3 (`mm_ren` low throughout).
  - `lsu_rvalid` in cycle 4 with `lsu_rdata`=0.
- Simultaneous IFU and LSU requests, held:
  - Without macro: LSU granted first; IFU granted after LSU's RESP.
  - With `MEM_ARB_RR_EN`: IFU first, then LSU; a third tie goes to IFU.
- `rst` asserted in the middle BUSY cycle of a MEM_LAT=3 store:
  - No `mm_wen` pulse and no `lsu_rvalid`.
  - Next cycle: state IDLE, all outputs 0.
- IFU raises `req` for one cycle while LSU owns the port, then drops it:
  - No `ifu_gnt` and no IFU access issued.
  - LSU response unaffected.
